// File: rtl/alu_mc.sv
// Multi-cycle ALU with a valid/ready handshake on both sides.
// Single-cycle logic and compare ops finish in one cycle; MUL uses a WIDTH-step shift-add loop.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] ALUop1,
    input  logic signed [WIDTH-1:0] ALUop2,
    input  logic [2:0]              ALUctrl,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] ALUout,
    output logic                    EQ,
    output logic                    Zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_EQ  = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    state_e           state, state_next;
    op_e              op;
    logic             is_mul;
    logic [WIDTH-1:0] alu_res;
    logic             eq_res;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic [CW-1:0]    cnt;

    assign op        = op_e'(ALUctrl);
    assign is_mul    = (op == OP_MUL);
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // Single-cycle result, taken straight from the live operands on the accepting edge.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        alu_res = '0;
        eq_res  = 1'b0;
        case (op)
            OP_ADD:  alu_res = ALUop1 + ALUop2;
            OP_SUB:  alu_res = ALUop1 - ALUop2;
            OP_AND:  alu_res = ALUop1 & ALUop2;
            OP_OR:   alu_res = ALUop1 | ALUop2;
            OP_XOR:  alu_res = ALUop1 ^ ALUop2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (ALUop1 < ALUop2)};
            OP_EQ:   eq_res  = (ALUop1 == ALUop2);
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid) state_next = is_mul ? BUSY : DONE;
            BUSY: if (cnt == LAST) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            ALUout <= '0;
            EQ     <= 1'b0;
            Zero   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_mul) begin
                            mcand  <= ALUop1;
                            mplier <= ALUop2;
                            acc    <= '0;
                            cnt    <= '0;
                            ALUout <= '0;
                            EQ     <= 1'b0;
                            Zero   <= 1'b0;
                        end else begin
                            ALUout <= alu_res;
                            EQ     <= eq_res;
                            Zero   <= (alu_res == '0);
                        end
                    end
                end
                BUSY: begin
                    // Operands live only in mcand/mplier here, so the input ports are free to change.
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        ALUout <= acc_next;
                        EQ     <= 1'b0;
                        Zero   <= (acc_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
